// File: rtl/log_capture_pkg.sv
// Shared types and default widths for the log capture controller.
// Samples are NB_DATA bits wide and are packed two per RAM word.
package log_capture_pkg;

    localparam int NB_DATA = 16;
    localparam int NB_ADDR = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    // Returns the last word address for a RAM of 2**nb_addr words.
    function automatic logic [31:0] last_word_addr(input int nb_addr);
        return (32'd1 << nb_addr) - 32'd1;
    endfunction

endpackage

// File: rtl/log_capture_ctrl_bram.sv
// Simple dual-port RAM with one write port and one registered read port.
// Neither the array nor the read register is reset, so it maps onto block RAM.
module log_bram #(
    parameter int NB_ADDR = 15,
    parameter int NB_WORD = 32
) (
    input  logic               clk100,
    input  logic               wr_en_i,
    input  logic [NB_ADDR-1:0] wr_addr_i,
    input  logic [NB_WORD-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [NB_ADDR-1:0] rd_addr_i,
    output logic [NB_WORD-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** NB_ADDR;

    logic [NB_WORD-1:0] mem_q [DEPTH];
    logic [NB_WORD-1:0] rd_data_q;

    always_ff @(posedge clk100) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk100) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/log_capture_ctrl.sv
// Captures consecutive filter samples two per word into block RAM until full,
// and serves word reads to the register file with one cycle of latency.
module log_capture_ctrl #(
    parameter int NB_DATA = log_capture_pkg::NB_DATA,
    parameter int NB_ADDR = log_capture_pkg::NB_ADDR
) (
    input  logic                 clk100,
    input  logic                 i_resetn,
    input  logic [NB_DATA-1:0]   i_filter_data,
    input  logic                 i_run_log,
    input  logic                 i_read_log,
    input  logic [NB_ADDR-1:0]   i_rd_addr,
    output logic [2*NB_DATA-1:0] o_rd_data,
    output logic                 o_mem_full,
    output logic                 o_busy,
    output logic [NB_ADDR-1:0]   o_wr_addr
);

    import log_capture_pkg::*;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(last_word_addr(NB_ADDR));
    localparam logic [NB_ADDR-1:0] ADDR_ONE  = NB_ADDR'(1);

    state_e               state_q, state_d;
    logic [NB_ADDR-1:0]   wr_addr_q, wr_addr_d;
    logic                 phase_q, phase_d;
    logic [NB_DATA-1:0]   hold_q, hold_d;
    logic                 run_q;
    logic                 rd_zero_q;
    logic                 run_start;
    logic                 ram_wr_en;
    logic                 ram_rd_en;
    logic [2*NB_DATA-1:0] ram_rd_data;

    assign run_start = i_run_log & ~run_q;

    always_ff @(posedge clk100) begin
        if (!i_resetn) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            phase_q   <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            phase_q   <= phase_d;
            run_q     <= i_run_log;
        end
    end

    // The hold register only ever feeds a write after being loaded, so no reset.
    always_ff @(posedge clk100) begin
        hold_q <= hold_d;
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        phase_d   = phase_q;
        hold_d    = hold_q;
        ram_wr_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_start) begin
                    state_d   = ST_CAPTURE;
                    wr_addr_d = '0;
                    phase_d   = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (run_start) begin
                    wr_addr_d = '0;
                    phase_d   = 1'b0;
                end else if (!phase_q) begin
                    hold_d  = i_filter_data;
                    phase_d = 1'b1;
                end else begin
                    ram_wr_en = 1'b1;
                    phase_d   = 1'b0;
                    // Pointer parks on the last word instead of wrapping.
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = ST_FULL;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                    end
                end
            end
            ST_FULL: begin
                if (run_start) begin
                    state_d   = ST_CAPTURE;
                    wr_addr_d = '0;
                    phase_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Blocked reads return zero; a flag masks the RAM output so its read
    // register can stay free of reset and still infer as block RAM.
    assign ram_rd_en = i_read_log & (state_q != ST_CAPTURE);

    always_ff @(posedge clk100) begin
        if (!i_resetn) begin
            rd_zero_q <= 1'b1;
        end else if (i_read_log) begin
            rd_zero_q <= (state_q == ST_CAPTURE);
        end
    end

    log_bram #(
        .NB_ADDR (NB_ADDR),
        .NB_WORD (2 * NB_DATA)
    ) u_bram (
        .clk100    (clk100),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (wr_addr_q),
        .wr_data_i ({i_filter_data, hold_q}),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (i_rd_addr),
        .rd_data_o (ram_rd_data)
    );

    assign o_rd_data  = rd_zero_q ? '0 : ram_rd_data;
    assign o_mem_full = (state_q == ST_FULL);
    assign o_busy     = (state_q == ST_CAPTURE);
    assign o_wr_addr  = wr_addr_q;

endmodule
